// File: rtl/simon_block_loader_if.sv
// Byte-stream and core-handshake signals of the SIMON block loader.
// The loader takes the slave side; the producer/core side takes master.
interface simon_block_loader_if #(
  parameter int N     = 24,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                loadData;
  logic                newData;
  logic [1:0][N-1:0]   blockIN;
  logic [CW-1:0]       fifo_count;

  modport slave (
    input  byte_in, byte_valid, loadData,
    output byte_ready, newData, blockIN, fifo_count
  );

  modport master (
    output byte_in, byte_valid, loadData,
    input  byte_ready, newData, blockIN, fifo_count
  );
endinterface

// File: rtl/simon_block_loader.sv
// Packs a byte stream into 2N-bit blocks, buffers them in a small FIFO and
// offers them one at a time to the SIMON core over newData/loadData.
module simon_block_loader #(
  parameter int N     = 24,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 nR,
  input  logic                 flush,
  simon_block_loader_if.slave  bus
);

  localparam int BW  = 2 * N;
  localparam int BPB = BW / 8;
  localparam int BCW = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPB - 1);
  localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    RELEASE
  } LoaderState;

  LoaderState       state;
  LoaderState       stateNext;

  logic [BCW-1:0]   byteCount;
  logic [BW-1:0]    assembly;
  logic [BW-1:0]    nextAssembly;
  logic [BW-1:0]    fifoMem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic [BW-1:0]    heldBlock;

  logic             lastByte;
  logic             fifoFull;
  logic             byteReady;
  logic             accept;
  logic             push;
  logic             pop;
  logic             loadHead;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Only the byte that would complete a block can be stalled; earlier bytes
  // of the next block always fit in the assembly register.
  assign lastByte     = (byteCount == LAST_BYTE);
  assign fifoFull     = (count == FULL_CNT);
  assign byteReady    = !(lastByte && fifoFull);
  assign accept       = bus.byte_valid && byteReady && !flush;
  assign push         = accept && lastByte;
  assign nextAssembly = (assembly << 8) | BW'(bus.byte_in);

  assign bus.byte_ready = byteReady;
  assign bus.newData    = (state == OFFER);
  assign bus.blockIN    = heldBlock;
  assign bus.fifo_count = count;

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    loadHead  = 1'b0;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && !bus.loadData) begin
            stateNext = OFFER;
            loadHead  = 1'b1;
          end
        end
        OFFER: begin
          if (bus.loadData) begin
            stateNext = RELEASE;
            pop       = 1'b1;
          end
        end
        RELEASE: begin
          // Waiting for loadData to drop keeps one long pulse to one pop.
          if (!bus.loadData) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      byteCount <= '0;
      assembly  <= '0;
    end else if (flush) begin
      byteCount <= '0;
    end else if (accept) begin
      assembly  <= nextAssembly;
      byteCount <= lastByte ? '0 : byteCount + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= nextAssembly;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= advance(wrPtr);
      end
      if (pop) begin
        rdPtr <= advance(rdPtr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // blockIN deliberately survives a flush; only reset clears it.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      heldBlock <= '0;
    end else if (loadHead) begin
      heldBlock <= fifoMem[rdPtr];
    end
  end

endmodule
